mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store unit for the MIPS pipeline, successor of the single-cycle MEM stage.
//  Drives a handshaked data memory (req/ack, variable latency) with word-aligned addresses and byte enables, no read-modify-write.
//  Aligns loads, including the LWL/LWR merge; builds store lanes, including SWL/SWR.
//  Stalls the pipeline while an access is outstanding and registers the writeback outputs.
// PARAMETERS
//  ADDR_W      32  address width; dm_addr = {addr_IN[ADDR_W-1:2],2'b00}
//  BIG_ENDIAN  1   1: byte offset 0 = bits[31:24]; 0: offset 0 = bits[7:0] (all lane maps mirrored)
//  TIMEOUT     64  cycles in REQ without dm_ack before a bus fault (>=2)
//  TO_W        7   timeout counter width, >= clog2(TIMEOUT+1)
// PORTS
//  CLK              in   1       clock, rising edge
//  RESET            in   1       synchronous, active-low reset
//  valid_IN         in   1       instruction present in MEM
//  ALU_Control_IN   in   6       operation code (see BEHAVIOUR)
//  addr_IN          in   ADDR_W  effective address / ALU result
//  MemRead_IN       in   1       load
//  MemWrite_IN      in   1       store
//  store_data_IN    in   32      rt value for stores
//  rt_old_IN        in   32      current rt value, merged by LWL/LWR
//  WriteRegister_IN in   5       destination register
//  RegWrite_IN      in   1       writeback enable
//  stall_OUT        out  1       upstream must hold all *_IN stable
//  WriteRegister_OUT out 5       registered destination
//  RegWrite_OUT     out  1       registered writeback enable
//  WriteData_OUT    out  32      registered load data or ALU result
//  fault_OUT        out  1       one-cycle pulse: misaligned access or timeout
//  dm_req / dm_we   out  1/1     memory request / write
//  dm_addr          out  ADDR_W  word-aligned address
//  dm_be            out  4       byte enables, bit i = bits[8i+7:8i]
//  dm_wdata         out  32      lane-positioned store data
//  dm_rdata / dm_ack in  32/1    read data, valid with ack
// BEHAVIOUR
//  Reset (RESET=0 at an edge): state IDLE, all outputs 0, counter 0. An outstanding request is abandoned; dm_req drops the next cycle.
//  Codes: LB 100001, LBU 101010, LH 101011, LHU 101100, LW/LL/LWC1 111101/101000/110101,
//   LWL 101101, LWR 101110, SB 101111, SH 110000, SW/SC 110001/110110, SWL 110010, SWR 110011.
//  FSM IDLE -> REQ -> IDLE. Not valid, or neither MemRead nor MemWrite: stay in IDLE; next edge registers
//   WriteData_OUT=addr_IN (zero-extended to 32) and RegWrite_OUT=RegWrite_IN&valid_IN. Latency 1, no stall.
//  Memory op with valid_IN in IDLE: stall_OUT=1 combinationally that cycle; next edge enters REQ.
//   In REQ: dm_req=1 with stable addr/be/wdata; stall_OUT=1.
//  dm_ack in REQ: at that edge, register aligned load data (loads) and RegWrite_IN; return to IDLE.
//   stall_OUT is 0 in the following cycle. Minimum memory-op latency is 2 cycles.
//  Timeout: the counter increments each REQ cycle without ack. When it equals TIMEOUT-1 without ack: pulse fault_OUT,
//   RegWrite_OUT=0, go to IDLE. Ack on that same cycle wins (no fault).
//  Misalignment (LH/LHU/SH addr[0]=1; word ops addr[1:0]!=0): no request; fault_OUT pulses, RegWrite_OUT=0, latency 1.
//  Load alignment (k=addr[1:0], big-endian offsets): LB/LBU byte k sign/zero-extended; LH/LHU halfword k/2.
//   LWL: {mem bytes k..3, rt_old low k bytes}. LWR: {rt_old high 3-k bytes, mem bytes 0..k}.
//  Stores: SB be=one lane; SH two lanes; SW 4'hF. SWL writes bytes k..3 = rt>>(8k). SWR writes bytes 0..k = rt<<(8(3-k)).
//   Unenabled lanes of dm_wdata are 0.
//  Stores write no register: RegWrite_OUT = RegWrite_IN (normally 0).
// TESTING
//  1. ADD-like op, addr_IN=32'h1234 -> WriteData_OUT=32'h1234 next cycle, stall_OUT never high.
//  2. LB at addr 0x101, mem word 0x11F23344, ack after 3 cycles -> WriteData_OUT=0xFFFFFFF2, stall 4 cycles.
//  3. LWL at addr 0x102, mem 0xAABBCCDD, rt_old 0x11223344 -> 0xCCDD3344. LWR at 0x101 -> 0x1122AABB.
//  4. SWR at 0x101, rt 0x11223344 -> dm_be=4'b1100, dm_wdata=0x33440000. SH at 0x103 -> fault_OUT, no dm_req.
//  5. No ack for TIMEOUT cycles -> one fault_OUT pulse, RegWrite_OUT=0. Repeat with ack on the last cycle -> data, no fault.
//  6. RESET=0 during REQ -> next cycle dm_req=0, stall_OUT=0, outputs 0. Repeat tests 2-4 with BIG_ENDIAN=0, mirrored lanes.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit driving a req/ack data memory with word-aligned addresses and byte enables.
// Aligns loads (including the LWL/LWR merge), builds store lanes (including SWL/SWR) and stalls while a request is outstanding.
module mem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int TIMEOUT    = 64,
    parameter int TO_W       = 7
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              valid_IN,
    input  logic [5:0]        ALU_Control_IN,
    input  logic [ADDR_W-1:0] addr_IN,
    input  logic              MemRead_IN,
    input  logic              MemWrite_IN,
    input  logic [31:0]       store_data_IN,
    input  logic [31:0]       rt_old_IN,
    input  logic [4:0]        WriteRegister_IN,
    input  logic              RegWrite_IN,
    output logic              stall_OUT,
    output logic [4:0]        WriteRegister_OUT,
    output logic              RegWrite_OUT,
    output logic [31:0]       WriteData_OUT,
    output logic              fault_OUT,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_ack,
    output logic              dbg_state_OUT
);
    // Handshake: dm_req rises with dm_addr/dm_be/dm_we/dm_wdata and holds them stable until a cycle with dm_ack
    // high; that cycle completes the transfer and dm_req drops the next cycle. While stall_OUT is high the
    // pipeline must hold every *_IN input stable.
    localparam logic [5:0] OP_LB  = 6'b100001, OP_LBU = 6'b101010, OP_LH  = 6'b101011, OP_LHU = 6'b101100;
    localparam logic [5:0] OP_LWL = 6'b101101, OP_LWR = 6'b101110, OP_SB  = 6'b101111, OP_SH  = 6'b110000;
    localparam logic [5:0] OP_SWL = 6'b110010, OP_SWR = 6'b110011;

    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;
    typedef enum logic [2:0] {F_BYTE, F_HALF, F_WORD, F_LEFT, F_RIGHT} fmt_t;

    state_t            r_state;
    logic              r_done;
    logic [TO_W-1:0]   r_cnt;
    logic [4:0]        r_wreg;
    logic              r_regwrite;
    logic [31:0]       r_wbdata;
    logic              r_fault;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;

    fmt_t        w_fmt;
    logic        w_sext;
    logic [1:0]  w_off;
    logic [4:0]  w_sh_o;
    logic [4:0]  w_sh_n;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_lmask;
    logic [31:0] w_rmask;
    logic [31:0] w_load;
    logic [3:0]  w_be;
    logic [31:0] w_st;
    logic        w_misaligned;
    logic        w_mem_op;
    logic [31:0] w_addr32;

    always_comb begin
        w_fmt  = F_WORD;
        w_sext = 1'b0;
        case (ALU_Control_IN)
            OP_LB:          begin w_fmt = F_BYTE; w_sext = 1'b1; end
            OP_LBU, OP_SB:  w_fmt = F_BYTE;
            OP_LH:          begin w_fmt = F_HALF; w_sext = 1'b1; end
            OP_LHU, OP_SH:  w_fmt = F_HALF;
            OP_LWL, OP_SWL: w_fmt = F_LEFT;
            OP_LWR, OP_SWR: w_fmt = F_RIGHT;
            default:        w_fmt = F_WORD;
        endcase
    end

    // w_off is the byte offset in big-endian numbering; little-endian mirrors it so one set of lane maps serves both.
    assign w_off    = BIG_ENDIAN ? addr_IN[1:0] : ~addr_IN[1:0];
    assign w_sh_o   = {w_off, 3'b000};
    assign w_sh_n   = {~w_off, 3'b000};
    assign w_byte   = 8'(dm_rdata >> w_sh_n);
    assign w_half   = w_off[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    assign w_lmask  = (32'h1 << w_sh_o) - 32'h1;
    assign w_rmask  = 32'hFFFF_FFFF >> w_sh_n;
    assign w_addr32 = 32'(addr_IN);
    assign w_mem_op = valid_IN && (MemRead_IN || MemWrite_IN);
    assign w_misaligned = ((w_fmt == F_HALF) && addr_IN[0]) ||
                          ((w_fmt == F_WORD) && (addr_IN[1:0] != 2'b00));

    always_comb begin
        case (w_fmt)
            F_BYTE:  w_load = {{24{w_sext & w_byte[7]}}, w_byte};
            F_HALF:  w_load = {{16{w_sext & w_half[15]}}, w_half};
            F_LEFT:  w_load = (dm_rdata << w_sh_o) | (rt_old_IN & w_lmask);
            F_RIGHT: w_load = (dm_rdata >> w_sh_n) | (rt_old_IN & ~w_rmask);
            default: w_load = dm_rdata;
        endcase
    end

    always_comb begin
        w_be = 4'hF;
        w_st = store_data_IN;
        case (w_fmt)
            F_BYTE: begin
                w_be = 4'b0001 << ~w_off;
                w_st = {24'h0, store_data_IN[7:0]} << w_sh_n;
            end
            F_HALF: begin
                w_be = w_off[1] ? 4'b0011 : 4'b1100;
                w_st = w_off[1] ? {16'h0, store_data_IN[15:0]} : {store_data_IN[15:0], 16'h0};
            end
            F_LEFT: begin
                w_be = 4'hF >> w_off;
                w_st = store_data_IN >> w_sh_o;
            end
            F_RIGHT: begin
                w_be = 4'hF << ~w_off;
                w_st = store_data_IN << w_sh_n;
            end
            default: begin
                w_be = 4'hF;
                w_st = store_data_IN;
            end
        endcase
    end

    // r_done marks the cycle after completion, when the pipeline still presents the finished instruction.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= S_IDLE; r_done <= 1'b0; r_cnt <= '0;
            r_wreg <= '0; r_regwrite <= 1'b0; r_wbdata <= '0; r_fault <= 1'b0;
            r_req <= 1'b0; r_we <= 1'b0; r_addr <= '0; r_be <= '0; r_wdata <= '0;
        end else begin
            r_fault <= 1'b0;
            r_wreg  <= WriteRegister_IN;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (r_done) begin
                        r_regwrite <= 1'b0;
                    end else if (!w_mem_op) begin
                        r_wbdata   <= w_addr32;
                        r_regwrite <= RegWrite_IN && valid_IN;
                    end else if (w_misaligned) begin
                        r_fault    <= 1'b1;
                        r_regwrite <= 1'b0;
                    end else begin
                        r_state    <= S_REQ;
                        r_cnt      <= '0;
                        r_regwrite <= 1'b0;
                        r_req      <= 1'b1;
                        r_we       <= MemWrite_IN;
                        r_addr     <= {addr_IN[ADDR_W-1:2], 2'b00};
                        r_be       <= w_be;
                        r_wdata    <= MemWrite_IN ? w_st : 32'h0;
                    end
                end
                S_REQ: begin
                    if (dm_ack || (r_cnt == TO_W'(TIMEOUT - 1))) begin
                        r_state <= S_IDLE; r_done <= 1'b1;
                        r_req <= 1'b0; r_we <= 1'b0; r_addr <= '0; r_be <= '0; r_wdata <= '0;
                        if (dm_ack) begin
                            r_regwrite <= RegWrite_IN && valid_IN;
                            r_wbdata   <= MemWrite_IN ? w_addr32 : w_load;
                        end else begin
                            r_regwrite <= 1'b0;
                            r_fault    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_OUT = RESET && ((r_state == S_REQ) ||
                                 ((r_state == S_IDLE) && !r_done && w_mem_op && !w_misaligned));
    assign WriteRegister_OUT = r_wreg;
    assign RegWrite_OUT      = r_regwrite;
    assign WriteData_OUT     = r_wbdata;
    assign fault_OUT         = r_fault;
    assign dm_req            = r_req;
    assign dm_we             = r_we;
    assign dm_addr           = r_addr;
    assign dm_be             = r_be;
    assign dm_wdata          = r_wdata;
    assign dbg_state_OUT     = (r_state == S_REQ);
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a big-endian and a little-endian instance share one stimulus stream; a byte-level
// model fills per-instance expected queues that are popped when each instruction's writeback appears.
module tb_mem_access_unit;
    localparam int TO = 8;
    localparam logic [5:0] OP_ADD = 6'b100000, OP_LB = 6'b100001, OP_LBU = 6'b101010, OP_LH = 6'b101011;
    localparam logic [5:0] OP_LHU = 6'b101100, OP_LW = 6'b111101, OP_LL = 6'b101000, OP_LWC1 = 6'b110101;
    localparam logic [5:0] OP_LWL = 6'b101101, OP_LWR = 6'b101110, OP_SB = 6'b101111, OP_SH = 6'b110000;
    localparam logic [5:0] OP_SW = 6'b110001, OP_SC = 6'b110110, OP_SWL = 6'b110010, OP_SWR = 6'b110011;

    logic CLK;
    logic RESET, valid_IN, MemRead_IN, MemWrite_IN, RegWrite_IN, dm_ack;
    logic [5:0] ALU_Control_IN;
    logic [31:0] addr_IN, store_data_IN, rt_old_IN, dm_rdata;
    logic [4:0] WriteRegister_IN;

    logic stall_be, rw_be, fault_be, req_be, we_be, dbg_be;
    logic stall_le, rw_le, fault_le, req_le, we_le, dbg_le;
    logic [4:0] wreg_be, wreg_le;
    logic [31:0] wb_be, wb_le, addr_be, addr_le, wd_be, wd_le;
    logic [3:0] be_be, be_le;

    int n_chk = 0;
    int n_err = 0;
    // entry: {check_data, wreg[4:0], fault, regwrite, data[31:0]}
    logic [39:0] exp_be_q[$];
    logic [39:0] exp_le_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(TO), .TO_W(4)) u_be (
        .CLK(CLK), .RESET(RESET), .valid_IN(valid_IN), .ALU_Control_IN(ALU_Control_IN), .addr_IN(addr_IN),
        .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN), .store_data_IN(store_data_IN), .rt_old_IN(rt_old_IN),
        .WriteRegister_IN(WriteRegister_IN), .RegWrite_IN(RegWrite_IN), .stall_OUT(stall_be),
        .WriteRegister_OUT(wreg_be), .RegWrite_OUT(rw_be), .WriteData_OUT(wb_be), .fault_OUT(fault_be),
        .dm_req(req_be), .dm_we(we_be), .dm_addr(addr_be), .dm_be(be_be), .dm_wdata(wd_be),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dbg_state_OUT(dbg_be));

    mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(TO), .TO_W(4)) u_le (
        .CLK(CLK), .RESET(RESET), .valid_IN(valid_IN), .ALU_Control_IN(ALU_Control_IN), .addr_IN(addr_IN),
        .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN), .store_data_IN(store_data_IN), .rt_old_IN(rt_old_IN),
        .WriteRegister_IN(WriteRegister_IN), .RegWrite_IN(RegWrite_IN), .stall_OUT(stall_le),
        .WriteRegister_OUT(wreg_le), .RegWrite_OUT(rw_le), .WriteData_OUT(wb_le), .fault_OUT(fault_le),
        .dm_req(req_le), .dm_we(we_le), .dm_addr(addr_le), .dm_be(be_le), .dm_wdata(wd_le),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dbg_state_OUT(dbg_le));

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_load(input logic [5:0] c);
        return c inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_LWC1, OP_LWL, OP_LWR};
    endfunction
    function automatic bit is_store(input logic [5:0] c);
        return c inside {OP_SB, OP_SH, OP_SW, OP_SC, OP_SWL, OP_SWR};
    endfunction
    function automatic bit misaligned(input logic [5:0] c, input logic [1:0] k);
        if (c inside {OP_LH, OP_LHU, OP_SH}) return k[0];
        if (c inside {OP_LW, OP_LL, OP_LWC1, OP_SW, OP_SC}) return k != 2'b00;
        return 1'b0;
    endfunction
    // lane (dm_be bit index) holding memory byte offset j
    function automatic int lane(input bit big, input int j);
        return big ? 3 - j : j;
    endfunction
    // register byte that pairs with memory byte offset j for LWL/SWL (left=1) or LWR/SWR, -1 if untouched
    function automatic int map_idx(input bit big, input bit left, input int j, input int k);
        if (left) return big ? ((j >= k) ? 3 - j + k : -1) : ((j <= k) ? 3 - k + j : -1);
        return big ? ((j <= k) ? k - j : -1) : ((j >= k) ? j - k : -1);
    endfunction

    function automatic logic [31:0] model_load(input bit big, input logic [5:0] c, input logic [1:0] ka,
                                               input logic [31:0] mem, input logic [31:0] rt);
        logic [7:0] mb [4];
        logic [15:0] h;
        logic [31:0] r;
        int k, kh, idx;
        k  = int'(ka);
        kh = k & 2;
        for (int j = 0; j < 4; j++) mb[j] = mem[8*lane(big, j) +: 8];
        h = big ? {mb[kh], mb[kh+1]} : {mb[kh+1], mb[kh]};
        case (c)
            OP_LB:  r = {{24{mb[k][7]}}, mb[k]};
            OP_LBU: r = {24'h0, mb[k]};
            OP_LH:  r = {{16{h[15]}}, h};
            OP_LHU: r = {16'h0, h};
            OP_LWL, OP_LWR: begin
                r = rt;
                for (int j = 0; j < 4; j++) begin
                    idx = map_idx(big, c == OP_LWL, j, k);
                    if (idx >= 0) r[8*idx +: 8] = mb[j];
                end
            end
            default: r = mem;
        endcase
        return r;
    endfunction

    function automatic logic [35:0] model_store(input bit big, input logic [5:0] c, input logic [1:0] ka,
                                                input logic [31:0] rt);
        logic [3:0] be;
        logic [31:0] wd;
        int k, ln, idx;
        k = int'(ka);
        be = 4'h0;
        wd = 32'h0;
        case (c)
            OP_SB: begin ln = lane(big, k); be[ln] = 1'b1; wd[8*ln +: 8] = rt[7:0]; end
            OP_SH: begin
                ln = lane(big, k);     be[ln] = 1'b1; wd[8*ln +: 8] = big ? rt[15:8] : rt[7:0];
                ln = lane(big, k + 1); be[ln] = 1'b1; wd[8*ln +: 8] = big ? rt[7:0] : rt[15:8];
            end
            OP_SWL, OP_SWR: begin
                for (int j = 0; j < 4; j++) begin
                    idx = map_idx(big, c == OP_SWL, j, k);
                    if (idx >= 0) begin ln = lane(big, j); be[ln] = 1'b1; wd[8*ln +: 8] = rt[8*idx +: 8]; end
                end
            end
            default: begin be = 4'hF; wd = rt; end
        endcase
        return {be, wd};
    endfunction

    task automatic sb_compare(input string tag, input bit big);
        logic [39:0] e, got;
        if (big) begin
            if (exp_be_q.size() == 0) begin check({tag, "_sb_empty_be"}, 40'd1, 40'd0); return; end
            e = exp_be_q.pop_front();
            got = {1'b0, wreg_be, fault_be, rw_be, wb_be};
        end else begin
            if (exp_le_q.size() == 0) begin check({tag, "_sb_empty_le"}, 40'd1, 40'd0); return; end
            e = exp_le_q.pop_front();
            got = {1'b0, wreg_le, fault_le, rw_le, wb_le};
        end
        check({tag, big ? "_fault_be" : "_fault_le"}, 40'(got[33]), 40'(e[33]));
        check({tag, big ? "_rw_be" : "_rw_le"}, 40'(got[32]), 40'(e[32]));
        check({tag, big ? "_wreg_be" : "_wreg_le"}, 40'(got[38:34]), 40'(e[38:34]));
        if (e[39]) check({tag, big ? "_data_be" : "_data_le"}, 40'(got[31:0]), 40'(e[31:0]));
    endtask

    // ack_at: REQ cycle (1-based) that carries dm_ack; 0 or > TO means the memory never answers
    task automatic do_op(input string tag, input logic [5:0] c, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rt, input logic [31:0] mem, input int ack_at, input logic [4:0] wreg);
        bit ld, st, mop, mis, acked, fin, saw_req;
        int req_n, stl_be, stl_le, cyc, exp_stl;
        logic [35:0] ms_be, ms_le;
        ld = is_load(c); st = is_store(c); mop = ld || st;
        mis = mop && misaligned(c, addr[1:0]);
        acked = (ack_at >= 1) && (ack_at <= TO);
        @(posedge CLK); #1;
        ALU_Control_IN = c; addr_IN = addr; store_data_IN = sd; rt_old_IN = rt; WriteRegister_IN = wreg;
        MemRead_IN = ld; MemWrite_IN = st; RegWrite_IN = !st; valid_IN = 1'b1;
        if (!mop) begin
            exp_be_q.push_back({1'b1, wreg, 1'b0, 1'b1, addr});
            exp_le_q.push_back({1'b1, wreg, 1'b0, 1'b1, addr});
            exp_stl = 0;
        end else if (mis || !acked) begin
            exp_be_q.push_back({1'b0, wreg, 1'b1, 1'b0, 32'h0});
            exp_le_q.push_back({1'b0, wreg, 1'b1, 1'b0, 32'h0});
            exp_stl = mis ? 0 : 1 + TO;
        end else begin
            exp_be_q.push_back({1'b1, wreg, 1'b0, ld, ld ? model_load(1'b1, c, addr[1:0], mem, rt) : addr});
            exp_le_q.push_back({1'b1, wreg, 1'b0, ld, ld ? model_load(1'b0, c, addr[1:0], mem, rt) : addr});
            exp_stl = 1 + ack_at;
        end
        ms_be = model_store(1'b1, c, addr[1:0], sd);
        ms_le = model_store(1'b0, c, addr[1:0], sd);
        fin = 0; saw_req = 0; req_n = 0; stl_be = 0; stl_le = 0; cyc = 0;
        while (!fin && cyc < 60) begin
            @(negedge CLK);
            cyc++;
            if (req_be) begin
                saw_req = 1;
                req_n++;
                if (req_n == 1) begin
                    check({tag, "_dm_addr"}, 40'(addr_be), 40'({addr[31:2], 2'b00}));
                    check({tag, "_dm_we"}, 40'(we_be), 40'(st));
                    if (st) begin
                        check({tag, "_be_be"}, 40'({be_be, wd_be}), 40'(ms_be));
                        check({tag, "_be_le"}, 40'({be_le, wd_le}), 40'(ms_le));
                    end
                end
                if (req_n == ack_at) begin dm_ack = 1'b1; dm_rdata = mem; end
            end
            if (stall_le) stl_le++;
            if (stall_be) stl_be++; else fin = 1;
            if (!fin) begin @(posedge CLK); #1; dm_ack = 1'b0; dm_rdata = $urandom; end
        end
        if (!fin) check({tag, "_bound"}, 40'(cyc), 40'(0));
        check({tag, "_stall_be"}, 40'(stl_be), 40'(exp_stl));
        check({tag, "_stall_le"}, 40'(stl_le), 40'(exp_stl));
        check({tag, "_req"}, 40'(saw_req), 40'(mop && !mis));
        if (saw_req) begin sb_compare(tag, 1'b1); sb_compare(tag, 1'b0); end
        @(posedge CLK); #1;
        valid_IN = 1'b0; MemRead_IN = 1'b0; MemWrite_IN = 1'b0; RegWrite_IN = 1'b0;
        if (!saw_req) begin @(negedge CLK); sb_compare(tag, 1'b1); sb_compare(tag, 1'b0); end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_be"}, {stall_be, rw_be, fault_be, req_be, we_be, dbg_be, wreg_be, wb_be}, 40'd0);
        check({tag, "_le"}, {stall_le, rw_le, fault_le, req_le, we_le, dbg_le, wreg_le, wb_le}, 40'd0);
        check({tag, "_dm"}, {addr_be[7:0], be_be, wd_be}, 40'd0);
    endtask

    logic [5:0] codes [16] = '{OP_ADD, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_LWC1,
                               OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW, OP_SC, OP_SWL, OP_SWR};

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; valid_IN = 1'b0; MemRead_IN = 1'b0; MemWrite_IN = 1'b0; RegWrite_IN = 1'b0;
        dm_ack = 1'b0; ALU_Control_IN = 6'h0; addr_IN = 32'h0; store_data_IN = 32'h0;
        rt_old_IN = 32'h0; dm_rdata = 32'h0; WriteRegister_IN = 5'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_all_zero("reset");
        RESET = 1'b1;

        do_op("add", OP_ADD, 32'h1234, 32'h0, 32'h0, 32'h0, 0, 5'd3);
        do_op("lb", OP_LB, 32'h101, 32'h0, 32'h0, 32'h11F23344, 3, 5'd4);
        do_op("lwl", OP_LWL, 32'h102, 32'h0, 32'h11223344, 32'hAABBCCDD, 1, 5'd5);
        do_op("lwr", OP_LWR, 32'h101, 32'h0, 32'h11223344, 32'hAABBCCDD, 2, 5'd6);
        do_op("swr", OP_SWR, 32'h101, 32'h11223344, 32'h0, 32'h0, 1, 5'd0);
        do_op("sh_mis", OP_SH, 32'h103, 32'h11223344, 32'h0, 32'h0, 1, 5'd0);
        do_op("lw_mis", OP_LW, 32'h102, 32'h0, 32'h0, 32'h0, 1, 5'd7);
        do_op("lw_to", OP_LW, 32'h200, 32'h0, 32'h0, 32'hDEADBEEF, 0, 5'd8);
        @(negedge CLK);
        check("to_pulse_be", 40'(fault_be), 40'd0);
        check("to_pulse_le", 40'(fault_le), 40'd0);
        do_op("lw_last", OP_LW, 32'h204, 32'h0, 32'h0, 32'hCAFEF00D, TO, 5'd9);

        // reset abandons an outstanding request
        @(posedge CLK); #1;
        ALU_Control_IN = OP_LW; addr_IN = 32'h300; MemRead_IN = 1'b1; RegWrite_IN = 1'b1;
        WriteRegister_IN = 5'd10; valid_IN = 1'b1;
        @(posedge CLK); @(negedge CLK);
        check("rst_req_up", 40'({req_be, dbg_be, req_le, dbg_le}), 40'hF);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); @(negedge CLK);
        check_all_zero("rst_req");
        valid_IN = 1'b0; MemRead_IN = 1'b0; RegWrite_IN = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;

        for (int n = 0; n < 40; n++) begin
            logic [5:0] c;
            c = codes[$urandom_range(0, 15)];
            do_op("rnd", c, 32'($urandom_range(0, 16'hFFFF)), $urandom, $urandom, $urandom,
                  $urandom_range(1, 4), 5'($urandom_range(1, 31)));
        end

        check("sb_left_be", 40'(exp_be_q.size()), 40'd0);
        check("sb_left_le", 40'(exp_le_q.size()), 40'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
